// File: rtl/expr_eval.sv
// expr_eval: evaluates a stream of ASCII characters of the form
// digit ( ('+'|'*') digit )* one character per clock. '*' binds tighter
// than '+'. The block reports the running value of the longest legal prefix,
// plus valid, error and overflow flags. It tracks the syntax in lock-step
// with the upstream recogniser, so its valid flag matches that recogniser's
// output on every cycle.
module expr_eval #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             error,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        NUM,
        OP,
        ERR
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   r_term;
    logic               r_pendMul;
    logic [WIDTH-1:0]   w_nextSum;
    logic [WIDTH-1:0]   w_nextTerm;
    logic               w_nextPendMul;
    logic               w_arithOvf;

    logic [WIDTH-1:0]   r_result;
    logic               r_valid;
    logic               r_error;
    logic               r_overflow;

    logic               w_isDigit;
    logic               w_isPlus;
    logic               w_isMul;
    logic [WIDTH-1:0]   w_digit;
    logic [2*WIDTH-1:0] w_productWide;
    logic [2*WIDTH-1:0] w_plusWide;
    logic [2*WIDTH-1:0] w_resultWide;
    logic               w_resultOvf;

    // ASCII digits 0x30..0x39 carry their value in the low nibble.
    assign w_isDigit = (in >= 8'h30) && (in <= 8'h39);
    assign w_isPlus  = (in == 8'h2B);
    assign w_isMul   = (in == 8'h2A);
    assign w_digit   = {{(WIDTH-4){1'b0}}, in[3:0]};

    // All arithmetic is done at double width so overflow is simply a non-zero upper half.
    assign w_productWide = {{WIDTH{1'b0}}, r_term} * {{(2*WIDTH-4){1'b0}}, in[3:0]};
    assign w_plusWide    = {{WIDTH{1'b0}}, r_sum} + {{WIDTH{1'b0}}, r_term};
    assign w_resultWide  = {{WIDTH{1'b0}}, w_nextSum} + {{WIDTH{1'b0}}, w_nextTerm};
    assign w_resultOvf   = (w_nextState == NUM) && (w_resultWide[2*WIDTH-1:WIDTH] != '0);

    // Next-state and next-operand logic: one character decides each transition.
    always_comb begin
        w_nextState   = r_state;
        w_nextSum     = r_sum;
        w_nextTerm    = r_term;
        w_nextPendMul = r_pendMul;
        w_arithOvf    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_isDigit) begin
                    w_nextState = NUM;
                    w_nextTerm  = w_digit;
                    w_nextSum   = '0;
                end else begin
                    w_nextState = ERR;
                end
            end
            NUM: begin
                if (w_isPlus) begin
                    w_nextState   = OP;
                    w_nextSum     = w_plusWide[WIDTH-1:0];
                    w_nextPendMul = 1'b0;
                    w_arithOvf    = (w_plusWide[2*WIDTH-1:WIDTH] != '0);
                end else if (w_isMul) begin
                    w_nextState   = OP;
                    w_nextPendMul = 1'b1;
                end else begin
                    w_nextState = ERR;
                end
            end
            OP: begin
                if (w_isDigit) begin
                    w_nextState = NUM;
                    if (r_pendMul) begin
                        w_nextTerm = w_productWide[WIDTH-1:0];
                        w_arithOvf = (w_productWide[2*WIDTH-1:WIDTH] != '0);
                    end else begin
                        w_nextTerm = w_digit;
                    end
                end else begin
                    w_nextState = ERR;
                end
            end
            default: begin
                w_nextState = ERR;
            end
        endcase
    end

    // State and operand registers; clr wins over any character on the same edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= IDLE;
            r_sum     <= '0;
            r_term    <= '0;
            r_pendMul <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_sum     <= w_nextSum;
            r_term    <= w_nextTerm;
            r_pendMul <= w_nextPendMul;
        end
    end

    // Output registers: result refreshes only when landing on a digit, so it holds the last legal value.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_nextState == NUM) begin
                r_result <= w_resultWide[WIDTH-1:0];
            end
            r_valid    <= (w_nextState == NUM);
            r_error    <= (w_nextState == ERR);
            r_overflow <= r_overflow | w_arithOvf | w_resultOvf;
        end
    end

    assign result   = r_result;
    assign valid    = r_valid;
    assign error    = r_error;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: directed character sequences with hand-computed results,
// checked after every relevant clock edge.
module tb_expr_eval;

    logic       clk;
    logic       clr;
    logic [7:0] in;
    logic [7:0] result;
    logic       valid;
    logic       error;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    expr_eval #(.WIDTH(8)) dut (
        .clk      (clk),
        .clr      (clr),
        .in       (in),
        .result   (result),
        .valid    (valid),
        .error    (error),
        .overflow (overflow)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one character for one edge, then settle away from the edge.
    task automatic applyStimulus(input logic [7:0] c);
        in = c;
        @(posedge clk);
        #1;
    endtask

    // One clr cycle with an arbitrary character on the input.
    task automatic applyClear(input logic [7:0] c);
        clr = 1'b1;
        applyStimulus(c);
        clr = 1'b0;
    endtask

    // Compare all four outputs against the expected values.
    task automatic checkOutput(input string tag, input logic [7:0] expResult,
                               input logic expValid, input logic expError,
                               input logic expOvf);
        checks++;
        assert (result === expResult) else begin
            errors++;
            $error("FAIL %s result: observed %0d expected %0d", tag, result, expResult);
        end
        checks++;
        assert (valid === expValid) else begin
            errors++;
            $error("FAIL %s valid: observed %b expected %b", tag, valid, expValid);
        end
        checks++;
        assert (error === expError) else begin
            errors++;
            $error("FAIL %s error: observed %b expected %b", tag, error, expError);
        end
        checks++;
        assert (overflow === expOvf) else begin
            errors++;
            $error("FAIL %s overflow: observed %b expected %b", tag, overflow, expOvf);
        end
    endtask

    // Directed sequence of expressions.
    initial begin
        clr = 1'b0;
        in  = 8'h00;
        #2;

        applyClear(8'h00);
        checkOutput("reset", 8'd0, 1'b0, 1'b0, 1'b0);

        // "1+2*3" = 7
        applyStimulus("1"); checkOutput("e1_c1", 8'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus("+"); checkOutput("e1_c2", 8'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus("2"); checkOutput("e1_c3", 8'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus("*"); checkOutput("e1_c4", 8'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("3"); checkOutput("e1_c5", 8'd7, 1'b1, 1'b0, 1'b0);

        // "2*3*4+5" = 29
        applyClear(8'h00);
        applyStimulus("2"); checkOutput("e2_c1", 8'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus("*");
        applyStimulus("3"); checkOutput("e2_c3", 8'd6, 1'b1, 1'b0, 1'b0);
        applyStimulus("*");
        applyStimulus("4"); checkOutput("e2_c5", 8'd24, 1'b1, 1'b0, 1'b0);
        applyStimulus("+"); checkOutput("e2_c6", 8'd24, 1'b0, 1'b0, 1'b0);
        applyStimulus("5"); checkOutput("e2_c7", 8'd29, 1'b1, 1'b0, 1'b0);

        // "9*9*9*9": product overflow from the 5th character on
        applyClear(8'h00);
        applyStimulus("9"); checkOutput("e3_c1", 8'd9, 1'b1, 1'b0, 1'b0);
        applyStimulus("*");
        applyStimulus("9"); checkOutput("e3_c3", 8'd81, 1'b1, 1'b0, 1'b0);
        applyStimulus("*");
        applyStimulus("9"); checkOutput("e3_c5", 8'd217, 1'b1, 1'b0, 1'b1);
        applyStimulus("*"); checkOutput("e3_c6", 8'd217, 1'b0, 1'b0, 1'b1);
        applyStimulus("9"); checkOutput("e3_c7", 8'd161, 1'b1, 1'b0, 1'b1);

        // "9*9*3+9*9": 243 + 81 = 324 wraps to 68 via the result sum
        applyClear(8'h00);
        applyStimulus("9");
        applyStimulus("*");
        applyStimulus("9");
        applyStimulus("*");
        applyStimulus("3"); checkOutput("e4_c5", 8'd243, 1'b1, 1'b0, 1'b0);
        applyStimulus("+");
        applyStimulus("9"); checkOutput("e4_c7", 8'd252, 1'b1, 1'b0, 1'b0);
        applyStimulus("*"); checkOutput("e4_c8", 8'd252, 1'b0, 1'b0, 1'b0);
        applyStimulus("9"); checkOutput("e4_c9", 8'd68, 1'b1, 1'b0, 1'b1);

        // "1++2": error from the 3rd character, result frozen at 1
        applyClear(8'h00);
        applyStimulus("1"); checkOutput("e5_c1", 8'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus("+"); checkOutput("e5_c2", 8'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus("+"); checkOutput("e5_c3", 8'd1, 1'b0, 1'b1, 1'b0);
        applyStimulus("2"); checkOutput("e5_c4", 8'd1, 1'b0, 1'b1, 1'b0);
        applyStimulus("8"); checkOutput("e5_c5", 8'd1, 1'b0, 1'b1, 1'b0);
        applyClear(8'h00);
        checkOutput("e5_clr", 8'd0, 1'b0, 1'b0, 1'b0);

        // Two digits in a row are illegal
        applyStimulus("4");
        applyStimulus("6"); checkOutput("e6_dd", 8'd4, 1'b0, 1'b1, 1'b0);

        // Illegal first characters
        applyClear(8'h00);
        applyStimulus("a"); checkOutput("e7_alpha", 8'd0, 1'b0, 1'b1, 1'b0);
        applyClear(8'h00);
        applyStimulus("+"); checkOutput("e7_plus", 8'd0, 1'b0, 1'b1, 1'b0);
        applyClear(8'h00);
        applyStimulus("/"); checkOutput("e7_below", 8'd0, 1'b0, 1'b1, 1'b0);
        applyClear(8'h00);
        applyStimulus(":"); checkOutput("e7_above", 8'd0, 1'b0, 1'b1, 1'b0);

        // Boundary digits '0' and '9' around an operator
        applyClear(8'h00);
        applyStimulus("0"); checkOutput("e8_c1", 8'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus("+");
        applyStimulus("9"); checkOutput("e8_c3", 8'd9, 1'b1, 1'b0, 1'b0);

        // "3*4", clr mid-stream with '7' discarded, then "5"
        applyClear(8'h00);
        applyStimulus("3");
        applyStimulus("*");
        applyStimulus("4"); checkOutput("e9_pre", 8'd12, 1'b1, 1'b0, 1'b0);
        applyClear("7");
        checkOutput("e9_clr", 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus("5"); checkOutput("e9_post", 8'd5, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
